mod_mult_product_source: RTL and testbench
==========================================

MOD_MULT_PRODUCT_SOURCE -- requirements
Module: mod_mult_product_source

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the accepted-product counter.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1: an operand pair is presented.
REQ-005 SHALL have port in_ready  output  1: the block accepts the operand pair this cycle.
REQ-006 SHALL have port in_a  input  30: operand a, unsigned.
REQ-007 SHALL have port in_b  input  30: operand b, unsigned.
REQ-008 SHALL have port in_q_sel  input  4: modulus index, 0..12, in moduli-table order.
REQ-009 SHALL have port out_valid  output  1: a product is presented to the 60-bit reducer.
REQ-010 SHALL have port out_ready  input  1: the reducer consumes the product this cycle.
REQ-011 SHALL have port out_prod  output  60: a*b, unsigned, full width.
REQ-012 SHALL have port out_q_sel  output  4: modulus index travelling with the product.
REQ-013 SHALL have port out_oor  output  1: set if a >= q or b >= q for the selected modulus.
REQ-014 SHALL have port prod_count  output  CNT_W: number of products handed over (out_valid & out_ready).

Function
REQ-015 SHALL use the modulus table 0..12 = 1068564481, 1069219841, 1070727169, 1071513601, 1072496641, 1073479681, 1068433409, 1068236801, 1065811969, 1065484289, 1064697857, 1063452673, 1063321601.
REQ-016 SHALL clamp in_q_sel values 13..15 to 12 at acceptance, so out_q_sel never exceeds 12.
REQ-017 SHALL accept an operand pair on a cycle when in_valid & in_ready are both high.
REQ-018 SHALL be a 3-stage pipeline:
- S1 registers the operands, the clamped q_sel and the out-of-range flag.
- S2 registers the four 15x15 partial products.
- S3 registers the summed 60-bit product, which drives out_*.
REQ-019 SHALL have latency 3: with out_ready held high, a pair accepted at cycle t appears with out_valid at cycle t+3.
REQ-020 SHALL sustain throughput of one pair per cycle while out_ready is high.
REQ-021 SHALL advance each stage k when its valid bit is low or stage k+1 advances; S3 advances when out_valid is low or out_ready is high.
REQ-022 SHALL drive in_ready as the S1 advance condition; a stall collapses bubbles and never drops or duplicates a product.
REQ-023 SHALL hold out_prod, out_q_sel and out_oor stable while out_valid is high and out_ready is low.
REQ-024 SHALL compute out_oor from unclamped operands against the clamped modulus; the product is still computed and forwarded when out_oor is set.
REQ-025 SHALL increment prod_count on every out_valid & out_ready cycle, wrapping from all-ones to 0 without a flag.
REQ-026 SHALL ignore in_a, in_b and in_q_sel when in_valid is low; pipeline contents SHALL NOT change from them.

Reset
REQ-027 SHALL, when rst_n is low at a clock edge:
- clear all stage valid bits, out_valid and prod_count to 0;
- clear out_prod, out_q_sel and out_oor to 0.
REQ-028 SHALL discard in-flight products on reset mid-operation; no product accepted before reset SHALL appear afterwards.
REQ-029 SHALL hold in_ready low while rst_n is low, and SHALL assert it in the first cycle after rst_n returns high.

Verification
REQ-030 Bench SHALL apply a=3, b=5, q_sel=0 with out_ready=1 -> 3 cycles later out_prod=15, out_q_sel=0, out_oor=0, prod_count=1.
REQ-031 Bench SHALL apply a=b=1073741823, q_sel=4 -> out_prod=0x0FFFFFFF80000001, out_oor=1.
REQ-032 Bench SHALL apply a=1068564481, b=1, first with q_sel=0 and then with q_sel=5 -> out_oor=1 and then out_oor=0; both out_prod=1068564481.
REQ-033 Bench SHALL apply q_sel=15, a=b=2 -> out_q_sel=12, out_prod=4.
REQ-034 Bench SHALL stream 10 back-to-back pairs with out_ready low for cycles 4..8 -> all 10 products emerge in order, none lost or duplicated, in_ready low while the pipeline is full, prod_count=10.
REQ-035 Bench SHALL assert rst_n=0 for 1 cycle with 3 products in flight -> out_valid=0 and prod_count=0 the next cycle, and none of the 3 products appears afterwards.

Source files
------------

// File: rtl/mod_mult_product_source.sv
// mod_mult_product_source
// Three-stage 30x30 -> 60-bit unsigned multiplier that feeds a modular reducer.
// Each operand pair carries a modulus index (0..12). The index travels with the
// product, together with a flag that is set when either operand is not below
// the selected modulus. Handshakes are valid/ready on both sides. The pipeline
// stalls without dropping products and collapses bubbles while it is stalled.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : operand pair presented
//   in_ready   : operand pair accepted this cycle
//   in_a, in_b : 30-bit unsigned operands
//   in_q_sel   : modulus index (13..15 are clamped to 12)
//   out_valid  : product presented to the reducer
//   out_ready  : reducer consumes the product this cycle
//   out_prod   : 60-bit product a*b
//   out_q_sel  : clamped modulus index travelling with the product
//   out_oor    : a >= q or b >= q for the selected modulus
//   prod_count : number of products handed over (wraps)
module mod_mult_product_source #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [29:0]      in_a,
   input  logic [29:0]      in_b,
   input  logic [3:0]       in_q_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [59:0]      out_prod,
   output logic [3:0]       out_q_sel,
   output logic             out_oor,
   output logic [CNT_W-1:0] prod_count
);

   localparam int DATA_W = 30;
   localparam int HALF_W = 15;
   localparam int PROD_W = 60;

   function automatic logic [3:0] clamp_sel(input logic [3:0] sel);
      return (sel > 4'd12) ? 4'd12 : sel;
   endfunction

   function automatic logic [DATA_W-1:0] q_modulus(input logic [3:0] sel);
      logic [DATA_W-1:0] q;
      case (sel)
         4'd0:    q = 30'd1068564481;
         4'd1:    q = 30'd1069219841;
         4'd2:    q = 30'd1070727169;
         4'd3:    q = 30'd1071513601;
         4'd4:    q = 30'd1072496641;
         4'd5:    q = 30'd1073479681;
         4'd6:    q = 30'd1068433409;
         4'd7:    q = 30'd1068236801;
         4'd8:    q = 30'd1065811969;
         4'd9:    q = 30'd1065484289;
         4'd10:   q = 30'd1064697857;
         4'd11:   q = 30'd1063452673;
         default: q = 30'd1063321601;
      endcase
      return q;
   endfunction

   logic              vld_p0, vld_p1, vld_p2;
   logic              adv_p0, adv_p1, adv_p2;
   logic [DATA_W-1:0] a_p0, b_p0;
   logic [3:0]        q_p0, q_p1, q_p2;
   logic              oor_p0, oor_p1, oor_p2;
   logic [DATA_W-1:0] pp_hh_p1, pp_hl_p1, pp_lh_p1, pp_ll_p1;
   logic [PROD_W-1:0] prod_p2;
   logic [PROD_W-1:0] sum_p1;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        sel_in;
   logic [DATA_W-1:0] q_in;

   // A stage may take new contents when it is empty or its successor moves on;
   // an empty stage therefore absorbs a bubble even while the output is stalled.
   assign adv_p2   = !vld_p2 || out_ready;
   assign adv_p1   = !vld_p1 || adv_p2;
   assign adv_p0   = !vld_p0 || adv_p1;
   assign in_ready = rst_n && adv_p0;

   assign sel_in = clamp_sel(in_q_sel);
   assign q_in   = q_modulus(sel_in);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         cnt    <= '0;
      end else begin
         if (adv_p0) vld_p0 <= in_valid;
         if (adv_p1) vld_p1 <= vld_p0;
         if (adv_p2) vld_p2 <= vld_p1;
         if (vld_p2 && out_ready) cnt <= cnt + CNT_W'(1);
      end
   end

   // Stage S1: operands, clamped index, out-of-range flag from unclamped operands
   always_ff @(posedge clk) begin
      if (in_valid && adv_p0) begin
         a_p0   <= in_a;
         b_p0   <= in_b;
         q_p0   <= sel_in;
         oor_p0 <= (in_a >= q_in) || (in_b >= q_in);
      end
   end

   // Stage S2: four 15x15 partial products
   always_ff @(posedge clk) begin
      if (vld_p0 && adv_p1) begin
         pp_hh_p1 <= DATA_W'(a_p0[29:HALF_W]) * DATA_W'(b_p0[29:HALF_W]);
         pp_hl_p1 <= DATA_W'(a_p0[29:HALF_W]) * DATA_W'(b_p0[HALF_W-1:0]);
         pp_lh_p1 <= DATA_W'(a_p0[HALF_W-1:0]) * DATA_W'(b_p0[29:HALF_W]);
         pp_ll_p1 <= DATA_W'(a_p0[HALF_W-1:0]) * DATA_W'(b_p0[HALF_W-1:0]);
         q_p1     <= q_p0;
         oor_p1   <= oor_p0;
      end
   end

   assign sum_p1 = (PROD_W'(pp_hh_p1) << 30)
                 + (PROD_W'(pp_hl_p1) << HALF_W)
                 + (PROD_W'(pp_lh_p1) << HALF_W)
                 +  PROD_W'(pp_ll_p1);

   // Stage S3: summed product; these registers drive the outputs and are cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_p2 <= '0;
         q_p2    <= '0;
         oor_p2  <= 1'b0;
      end else if (vld_p1 && adv_p2) begin
         prod_p2 <= sum_p1;
         q_p2    <= q_p1;
         oor_p2  <= oor_p1;
      end
   end

   assign out_valid  = vld_p2;
   assign out_prod   = prod_p2;
   assign out_q_sel  = q_p2;
   assign out_oor    = oor_p2;
   assign prod_count = cnt;

endmodule

// File: tb/tb_mod_mult_product_source.sv
module tb_mod_mult_product_source;

   typedef struct packed {
      logic [59:0] prod;
      logic [3:0]  q;
      logic        oor;
   } exp_t;

   localparam logic [29:0] MODS [13] = '{
      30'd1068564481, 30'd1069219841, 30'd1070727169, 30'd1071513601,
      30'd1072496641, 30'd1073479681, 30'd1068433409, 30'd1068236801,
      30'd1065811969, 30'd1065484289, 30'd1064697857, 30'd1063452673,
      30'd1063321601};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [29:0] in_a = '0;
   logic [29:0] in_b = '0;
   logic [3:0]  in_q_sel = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [59:0] out_prod;
   logic [3:0]  out_q_sel;
   logic        out_oor;
   logic [15:0] prod_count;

   int checks = 0;
   int errors = 0;
   int seen = 0;
   exp_t sb[$];

   logic [59:0] last_prod;
   logic [3:0]  last_q;
   logic        last_oor;
   logic        stall_prev = 1'b0;
   logic [59:0] hold_prod;
   logic [3:0]  hold_q;
   logic        hold_oor;

   mod_mult_product_source #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_q_sel(in_q_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_prod(out_prod), .out_q_sel(out_q_sel), .out_oor(out_oor),
      .prod_count(prod_count));

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [29:0] a, input logic [29:0] b, input logic [3:0] q);
      exp_t e;
      logic [59:0] pa, pb;
      logic [3:0] qc;
      qc = (q > 4'd12) ? 4'd12 : q;
      pa = {30'd0, a};
      pb = {30'd0, b};
      e.prod = pa * pb;
      e.q = qc;
      e.oor = (a >= MODS[qc]) || (b >= MODS[qc]);
      return e;
   endfunction

   // Scoreboard monitor: every handover must match the oldest expected entry,
   // and a stalled output must not change.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_prod !== hold_prod || out_q_sel !== hold_q || out_oor !== hold_oor) begin
               errors++;
               $display("FAIL stall_hold: got v=%b prod=%h q=%0d oor=%b want v=1 prod=%h q=%0d oor=%b",
                        out_valid, out_prod, out_q_sel, out_oor, hold_prod, hold_q, hold_oor);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            seen++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_product: got prod=%h q=%0d with nothing expected", out_prod, out_q_sel);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (out_prod !== e.prod || out_q_sel !== e.q || out_oor !== e.oor) begin
                  errors++;
                  $display("FAIL product: got prod=%h q=%0d oor=%b want prod=%h q=%0d oor=%b",
                           out_prod, out_q_sel, out_oor, e.prod, e.q, e.oor);
               end
            end
            last_prod = out_prod;
            last_q    = out_q_sel;
            last_oor  = out_oor;
         end
         stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
         hold_prod  = out_prod;
         hold_q     = out_q_sel;
         hold_oor   = out_oor;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      seen = 0;
   endtask

   task automatic send_one(input logic [29:0] a, input logic [29:0] b, input logic [3:0] q);
      bit acc = 0;
      int n = 0;
      in_a = a; in_b = b; in_q_sel = q; in_valid = 1'b1;
      while (!acc && n < 20) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            acc = 1;
            sb.push_back(model(a, b, q));
         end
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d products outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || prod_count !== 16'd0 ||
          out_prod !== 60'd0 || out_q_sel !== 4'd0 || out_oor !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b v=%b cnt=%0d prod=%h q=%0d oor=%b want all 0",
                  in_ready, out_valid, prod_count, out_prod, out_q_sel, out_oor);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      do_reset();
      in_a = 30'd3; in_b = 30'd5; in_q_sel = 4'd0; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_accept: in_ready=%b want 1", in_ready);
      end
      sb.push_back(model(30'd3, 30'd5, 4'd0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: cycle %0d out_valid=%b want 0", c, out_valid);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_prod !== 60'd15 || out_q_sel !== 4'd0 || out_oor !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency3: got v=%b prod=%0d q=%0d oor=%b want v=1 prod=15 q=0 oor=0",
                  out_valid, out_prod, out_q_sel, out_oor);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (prod_count !== 16'd1) begin
         errors++;
         $display("FAIL basic_count: got %0d want 1", prod_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_max_operands();
      send_one(30'h3FFFFFFF, 30'h3FFFFFFF, 4'd4);
      wait_drain();
      checks++;
      if (last_prod !== 60'h0FFFFFFF80000001 || last_oor !== 1'b1 || last_q !== 4'd4) begin
         errors++;
         $display("FAIL max_operands: got prod=%h oor=%b q=%0d want prod=0FFFFFFF80000001 oor=1 q=4",
                  last_prod, last_oor, last_q);
      end
   endtask

   task automatic test_oor();
      send_one(30'd1068564481, 30'd1, 4'd0);
      wait_drain();
      checks++;
      if (last_oor !== 1'b1 || last_prod !== 60'd1068564481) begin
         errors++;
         $display("FAIL oor_q0: got oor=%b prod=%0d want oor=1 prod=1068564481", last_oor, last_prod);
      end
      send_one(30'd1068564481, 30'd1, 4'd5);
      wait_drain();
      checks++;
      if (last_oor !== 1'b0 || last_prod !== 60'd1068564481) begin
         errors++;
         $display("FAIL oor_q5: got oor=%b prod=%0d want oor=0 prod=1068564481", last_oor, last_prod);
      end
   endtask

   task automatic test_clamp();
      send_one(30'd2, 30'd2, 4'd15);
      wait_drain();
      checks++;
      if (last_q !== 4'd12 || last_prod !== 60'd4) begin
         errors++;
         $display("FAIL clamp: got q=%0d prod=%0d want q=12 prod=4", last_q, last_prod);
      end
   endtask

   task automatic test_ignore_idle();
      logic [15:0] cnt0;
      int vcount = 0;
      cnt0 = prod_count;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_a = 30'($urandom); in_b = 30'($urandom); in_q_sel = 4'($urandom);
         @(negedge clk);
         if (out_valid === 1'b1) vcount++;
         @(posedge clk); #1;
      end
      checks++;
      if (vcount != 0 || prod_count !== cnt0) begin
         errors++;
         $display("FAIL idle_ignored: got valids=%0d cnt=%0d want valids=0 cnt=%0d", vcount, prod_count, cnt0);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               bit acc = 0;
               int n = 0;
               logic [29:0] a, b;
               logic [3:0] q;
               a = 30'(100 + i * 7919);
               b = 30'((i + 1) * 12345);
               q = 4'(i % 13);
               in_a = a; in_b = b; in_q_sel = q; in_valid = 1'b1;
               while (!acc && n < 40) begin
                  @(negedge clk);
                  if (in_ready === 1'b1) begin
                     acc = 1;
                     sb.push_back(model(a, b, q));
                  end
                  @(posedge clk); #1;
                  n++;
               end
               if (!acc) begin
                  checks++; errors++;
                  $display("FAIL b2b_accept_timeout: pair %0d never accepted", i);
               end
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 20; c++) begin
               out_ready = !(c >= 4 && c <= 8);
               @(negedge clk);
               if (c >= 4 && c <= 8) begin
                  checks++;
                  if (in_ready !== 1'b0) begin
                     errors++;
                     $display("FAIL b2b_full_ready: cycle %0d in_ready=%b want 0", c, in_ready);
                  end
               end
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      checks++;
      if (prod_count !== 16'd10 || seen != 10) begin
         errors++;
         $display("FAIL b2b_count: got cnt=%0d seen=%0d want 10 and 10", prod_count, seen);
      end
   endtask

   task automatic test_reset_mid();
      int vcount = 0;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a = 30'(1000 + i); in_b = 30'(77 + i); in_q_sel = 4'(i); in_valid = 1'b1;
         @(negedge clk);
         if (in_ready === 1'b1) sb.push_back(model(in_a, in_b, in_q_sel));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || sb.size() != 3) begin
         errors++;
         $display("FAIL mid_before_reset: got rdy=%b v=%b inflight=%0d want rdy=0 v=1 inflight=3",
                  in_ready, out_valid, sb.size());
      end
      sb.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || prod_count !== 16'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_after_reset: got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1",
                  out_valid, prod_count, in_ready);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (out_valid === 1'b1) vcount++;
      end
      checks++;
      if (vcount != 0 || prod_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_discarded: got valids=%0d cnt=%0d want 0 and 0", vcount, prod_count);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_operands();
      test_oor();
      test_clamp();
      test_ignore_idle();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
